// File: rtl/lsu_dmem_master.sv
// Single-outstanding RV32I load/store initiator on a valid/ready dmem port with a 1-cycle response.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of being aligned down.
module lsu_dmem_master #(
  parameter int RD_W           = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_is_store_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [31:0]     req_addr_i,
  input  logic [31:0]     req_wdata_i,
  input  logic [RD_W-1:0] req_rd_i,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [31:0]     mem_addr_o,
  output logic [31:0]     mem_wdata_o,
  input  logic            mem_rvalid_i,
  output logic            mem_rready_o,
  input  logic [31:0]     mem_rdata_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic            wb_we_o,
  output logic [RD_W-1:0] wb_rd_o,
  output logic [31:0]     wb_data_o,
  output logic            wb_err_o,
  output logic [1:0]      state_dbg_o
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_RESP     = 2'd3
  } state_e;

  // Handshake rule on every port: a transfer happens on a rising edge where valid and ready are both high.
  state_e            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              illegal_op;
  logic              misaligned;
  logic [31:0]       addr_eff;
  logic              timeout;
  logic [3:0]        be;
  logic [31:0]       wdata_lanes;
  logic [31:0]       rd_shift_b;
  logic [31:0]       rd_shift_h;
  logic [31:0]       load_ext;

  always_comb begin
    illegal_op = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11) ||
                 (req_is_store_i && req_funct3_i[2]);
    addr_eff   = req_addr_i;
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                 ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
    if (req_funct3_i[1:0] == 2'b01) begin
      addr_eff[0] = 1'b0;
    end else if (req_funct3_i[1:0] == 2'b10) begin
      addr_eff[1:0] = 2'b00;
    end
`endif
  end

  // Lane steering works from the latched (already aligned) address.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        be          = 4'b0001 << addr_q[1:0];
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be          = 4'b0011 << {addr_q[1], 1'b0};
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        be          = 4'b1111;
        wdata_lanes = wdata_q;
      end
    endcase
    rd_shift_b = mem_rdata_i >> {addr_q[1:0], 3'b000};
    rd_shift_h = mem_rdata_i >> {addr_q[1], 4'b0000};
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_shift_b[7]}}, rd_shift_b[7:0]};
      3'b100:  load_ext = {24'd0, rd_shift_b[7:0]};
      3'b001:  load_ext = {{16{rd_shift_h[15]}}, rd_shift_h[15:0]};
      3'b101:  load_ext = {16'd0, rd_shift_h[15:0]};
      default: load_ext = mem_rdata_i;
    endcase
  end

  assign timeout = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    data_d     = data_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    req_ready_o  = 1'b0;
    mem_valid_o  = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    mem_addr_o   = 32'd0;
    mem_wdata_o  = 32'd0;
    mem_rready_o = 1'b0;
    wb_valid_o   = 1'b0;
    wb_we_o      = 1'b0;
    wb_rd_o      = '0;
    wb_data_o    = 32'd0;
    wb_err_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_o = !rst_i;
        if (req_valid_i) begin
          is_store_d = req_is_store_i;
          funct3_d   = req_funct3_i;
          addr_d     = addr_eff;
          wdata_d    = req_wdata_i;
          rd_d       = req_rd_i;
          data_d     = 32'd0;
          cnt_d      = '0;
          if (illegal_op || misaligned) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        mem_valid_o  = 1'b1;
        mem_rready_o = 1'b1;
        mem_we_o     = is_store_q;
        mem_be_o     = be;
        mem_addr_o   = addr_q;
        mem_wdata_o  = wdata_lanes;
        cnt_d        = cnt_q + 1'b1;
        if (mem_ready_i) begin
          state_d = S_WAIT_RSP;
        end else if (timeout) begin
          err_d   = 1'b1;
          data_d  = 32'd0;
          state_d = S_RESP;
        end
      end
      S_WAIT_RSP: begin
        mem_rready_o = 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (mem_rvalid_i) begin
          data_d  = is_store_q ? 32'd0 : load_ext;
          state_d = S_RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          data_d  = 32'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        wb_valid_o = 1'b1;
        wb_we_o    = !is_store_q && !err_q;
        wb_rd_o    = rd_q;
        wb_data_o  = data_q;
        wb_err_o   = err_q;
        if (wb_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rd_q       <= '0;
      data_q     <= 32'd0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master: a driver issues ops, a dmem responder answers, and
// scoreboard monitors compare memory requests and writeback completions against expected queues.
module tb_lsu_dmem_master;

  localparam int          RD_W = 5;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct packed {
    logic            we;
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
    logic            err;
    logic [7:0]      lat;
    logic [3:0]      hold;
  } wb_exp_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic            req_is_store_i = 1'b0;
  logic [2:0]      req_funct3_i = 3'd0;
  logic [31:0]     req_addr_i = 32'd0;
  logic [31:0]     req_wdata_i = 32'd0;
  logic [RD_W-1:0] req_rd_i = '0;
  logic            mem_valid_o;
  logic            mem_ready_i = 1'b1;
  logic            mem_we_o;
  logic [3:0]      mem_be_o;
  logic [31:0]     mem_addr_o;
  logic [31:0]     mem_wdata_o;
  logic            mem_rvalid_i = 1'b0;
  logic            mem_rready_o;
  logic [31:0]     mem_rdata_i = 32'd0;
  logic            wb_valid_o;
  logic            wb_ready_i = 1'b1;
  logic            wb_we_o;
  logic [RD_W-1:0] wb_rd_o;
  logic [31:0]     wb_data_o;
  logic            wb_err_o;
  logic [1:0]      state_dbg_o;

  wb_exp_t  exp_q[$];
  mem_exp_t exp_mem_q[$];
  int       n_vec = 0;
  int       n_miss = 0;
  int       cyc = 0;
  int       accept_cyc = 0;
  logic     rsp_en = 1'b1;
  logic [31:0] next_rdata = 32'd0;
  int       late_req = 0;
  int       late_done = 0;
  logic     seen = 1'b0;
  int       left = 0;
  wb_exp_t  cur;

  lsu_dmem_master #(.RD_W(RD_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_is_store_i(req_is_store_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_rd_i(req_rd_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .wb_err_o(wb_err_o), .state_dbg_o(state_dbg_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // dmem responder: answers each handshake one cycle later, or injects a stray rvalid on request
  always begin
    @(negedge clk);
    if (late_req != late_done) begin
      late_done = late_done + 1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'd0;
    end else if (!rst_i && mem_valid_o && mem_ready_i && rsp_en) begin
      @(posedge clk); #1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = next_rdata;
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'd0;
    end
  end

  // memory request monitor
  always begin
    mem_exp_t m;
    @(negedge clk);
    if (!rst_i && mem_valid_o) begin
      if (exp_mem_q.size() == 0) begin
        check("mem_unexpected", 32'd1, 32'd0);
      end else if (mem_ready_i) begin
        m = exp_mem_q.pop_front();
        check("mem_we", {31'd0, mem_we_o}, {31'd0, m.we});
        check("mem_be", {28'd0, mem_be_o}, {28'd0, m.be});
        check("mem_addr", mem_addr_o, m.addr);
        check("mem_wdata", mem_wdata_o, m.wdata);
      end
    end
  end

  // writeback monitor: compares on first appearance, then re-checks every stalled cycle
  always begin
    @(negedge clk);
    if (rst_i) begin
      seen = 1'b0;
    end else if (wb_valid_o) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 32'd1, 32'd0);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
          check("wb_latency", cyc - accept_cyc, {24'd0, cur.lat});
        end
        seen = 1'b1;
        left = int'(cur.hold);
      end
      check("wb_we", {31'd0, wb_we_o}, {31'd0, cur.we});
      check("wb_rd", {27'd0, wb_rd_o}, {27'd0, cur.rd});
      check("wb_data", wb_data_o, cur.data);
      check("wb_err", {31'd0, wb_err_o}, {31'd0, cur.err});
      check("req_ready_busy", {31'd0, req_ready_o}, 32'd0);
      wb_ready_i = (left == 0);
      if (left == 0) seen = 1'b0;
      else left--;
    end
  end

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [RD_W-1:0] rd);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_is_store_i = st; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        accept_cyc = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [RD_W-1:0] rd, input logic [31:0] rdata,
                       input logic mem_en, input logic [3:0] m_be, input logic [31:0] m_addr,
                       input logic [31:0] m_wdata, input logic e_we, input logic [31:0] e_data,
                       input logic e_err, input int e_lat, input int hold);
    wb_exp_t  e;
    mem_exp_t m;
    next_rdata = rdata;
    if (mem_en) begin
      m.we = st; m.be = m_be; m.addr = m_addr; m.wdata = m_wdata;
      exp_mem_q.push_back(m);
    end
    e.we = e_we; e.rd = rd; e.data = e_data; e.err = e_err;
    e.lat = 8'(e_lat); e.hold = 4'(hold);
    exp_q.push_back(e);
    drive_req(st, f3, addr, wdata, rd);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !seen) break;
    end
    if (exp_q.size() != 0 || seen) begin
      check("wb_complete_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    check("rst_mem_rready", {31'd0, mem_rready_o}, 32'd0);
    check("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rst_wb_data", wb_data_o, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'd0, req_ready_o}, 32'd1);

    //    st   f3      addr         wdata         rd    rdata         mem be       m_addr       m_wdata       we   data          err lat hold
    issue(1'b1, 3'b010, BASE+32'h10, 32'hDEADBEEF, 5'd0, 32'h0,        1, 4'b1111, BASE+32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        0, 3, 0);
    issue(1'b1, 3'b000, BASE+32'h13, 32'h000000A5, 5'd0, 32'h0,        1, 4'b1000, BASE+32'h13, 32'hA5A5A5A5, 1'b0, 32'h0,        0, 3, 0);
    issue(1'b0, 3'b000, BASE+32'h13, 32'h0,        5'd5, 32'hA5000000, 1, 4'b1000, BASE+32'h13, 32'h0,        1'b1, 32'hFFFFFFA5, 0, 3, 0);
    issue(1'b0, 3'b100, BASE+32'h13, 32'h0,        5'd6, 32'hA5000000, 1, 4'b1000, BASE+32'h13, 32'h0,        1'b1, 32'h000000A5, 0, 3, 0);
    issue(1'b0, 3'b001, BASE+32'h12, 32'h0,        5'd7, 32'h80010000, 1, 4'b1100, BASE+32'h12, 32'h0,        1'b1, 32'hFFFF8001, 0, 3, 0);
    issue(1'b0, 3'b101, BASE+32'h12, 32'h0,        5'd7, 32'h80010000, 1, 4'b1100, BASE+32'h12, 32'h0,        1'b1, 32'h00008001, 0, 3, 0);
    issue(1'b1, 3'b001, BASE+32'h02, 32'h00001234, 5'd0, 32'h0,        1, 4'b1100, BASE+32'h02, 32'h12341234, 1'b0, 32'h0,        0, 3, 0);
    issue(1'b0, 3'b000, BASE+32'h01, 32'h0,        5'd9, 32'h00007F00, 1, 4'b0010, BASE+32'h01, 32'h0,        1'b1, 32'h0000007F, 0, 3, 0);
    // illegal encodings fault at cycle 1 with no memory request
    issue(1'b0, 3'b011, BASE,        32'h0,        5'd10, 32'h0,       0, 4'b0000, 32'h0,       32'h0,        1'b0, 32'h0,        1, 1, 0);
    issue(1'b1, 3'b100, BASE,        32'h55,       5'd0, 32'h0,        0, 4'b0000, 32'h0,       32'h0,        1'b0, 32'h0,        1, 1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, BASE+32'h11, 32'h0,        5'd11, 32'hCAFEF00D, 0, 4'b0000, 32'h0,      32'h0,        1'b0, 32'h0,        1, 1, 0);
    issue(1'b0, 3'b001, BASE+32'h13, 32'h0,        5'd12, 32'hBEEF0000, 0, 4'b0000, 32'h0,      32'h0,        1'b0, 32'h0,        1, 1, 0);
`else
    issue(1'b0, 3'b010, BASE+32'h11, 32'h0,        5'd11, 32'hCAFEF00D, 1, 4'b1111, BASE+32'h10, 32'h0,       1'b1, 32'hCAFEF00D, 0, 3, 0);
    issue(1'b0, 3'b001, BASE+32'h13, 32'h0,        5'd12, 32'hBEEF0000, 1, 4'b1100, BASE+32'h12, 32'h0,       1'b1, 32'hFFFFBEEF, 0, 3, 0);
`endif
    // no response: bus error after TO cycles in REQ/WAIT_RSP
    rsp_en = 1'b0;
    issue(1'b0, 3'b010, BASE+32'h20, 32'h0,        5'd13, 32'h0,       1, 4'b1111, BASE+32'h20, 32'h0,        1'b0, 32'h0,        1, TO+1, 0);
    rsp_en = 1'b1;
    // writeback back-pressure for 3 cycles
    issue(1'b0, 3'b010, BASE+32'h24, 32'h0,        5'd14, 32'h12345678, 1, 4'b1111, BASE+32'h24, 32'h0,       1'b1, 32'h12345678, 0, 3, 3);

    // reset while waiting for the response; a stray rvalid afterwards must produce nothing
    rsp_en = 1'b0;
    begin
      mem_exp_t m;
      m.we = 1'b0; m.be = 4'b1111; m.addr = BASE + 32'h30; m.wdata = 32'h0;
      exp_mem_q.push_back(m);
    end
    drive_req(1'b0, 3'b010, BASE + 32'h30, 32'h0, 5'd15);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", {31'd0, req_ready_o}, 32'd0);
    check("midrst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    check("midrst_mem_rready", {31'd0, mem_rready_o}, 32'd0);
    check("midrst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    rsp_en = 1'b1;
    late_req = late_req + 1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_idle", {30'd0, state_dbg_o}, 32'd0);
    issue(1'b0, 3'b010, BASE+32'h28, 32'h0,        5'd16, 32'h0BADF00D, 1, 4'b1111, BASE+32'h28, 32'h0,       1'b1, 32'h0BADF00D, 0, 3, 0);

    repeat (4) @(negedge clk);
    check("mem_q_drained", exp_mem_q.size(), 32'd0);
    check("wb_q_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
